// File: rtl/bullet_sched_if.sv
// Player-request and slot-engine bundle between the bullet scheduler and its environment.
interface bullet_sched_if #(
    parameter int SLOTS = 4
) ();
    logic             timer;
    logic             fire_a;
    logic             fire_b;
    logic [10:0]      pos_a_x;
    logic [10:0]      pos_a_y;
    logic [10:0]      pos_b_x;
    logic [10:0]      pos_b_y;
    logic             dir_a;
    logic             dir_b;
    logic [SLOTS-1:0] slot_done;
    logic [SLOTS-1:0] slot_trig;
    logic [10:0]      slot_x;
    logic [10:0]      slot_y;
    logic             slot_d;
    logic [SLOTS-1:0] slot_busy;
    logic [SLOTS-1:0] slot_owner;
    logic             ack_a;
    logic             ack_b;

    modport master (
        output timer, fire_a, fire_b, pos_a_x, pos_a_y, pos_b_x, pos_b_y,
               dir_a, dir_b, slot_done,
        input  slot_trig, slot_x, slot_y, slot_d, slot_busy, slot_owner,
               ack_a, ack_b
    );

    modport slave (
        input  timer, fire_a, fire_b, pos_a_x, pos_a_y, pos_b_x, pos_b_y,
               dir_a, dir_b, slot_done,
        output slot_trig, slot_x, slot_y, slot_d, slot_busy, slot_owner,
               ack_a, ack_b
    );
endinterface

// File: rtl/bullet_sched.sv
// Fire scheduler: arbitrates two players onto a pool of bullet engines with
// per-player cooldown and live-bullet cap, and reclaims slots on off-screen reports.
module bullet_sched #(
    parameter int SLOTS    = 4,
    parameter int MAX_PER  = 2,
    parameter int COOLDOWN = 8
) (
    input logic           clk,
    input logic           rst,
    bullet_sched_if.slave bus
);
    localparam int CW = $clog2(SLOTS + 1);
    localparam int IW = $clog2(SLOTS);

    logic [SLOTS-1:0] busy_q;
    logic [SLOTS-1:0] owner_q;
    logic [SLOTS-1:0] trig_q;
    logic [10:0]      x_q;
    logic [10:0]      y_q;
    logic             d_q;
    logic             ack_a_q;
    logic             ack_b_q;
    logic [CW-1:0]    cnt_a_q;
    logic [CW-1:0]    cnt_b_q;
    logic [7:0]       cd_a_q;
    logic [7:0]       cd_b_q;
    logic             rr_q;

    logic             free_any;
    logic [IW-1:0]    free_idx;
    logic [SLOTS-1:0] free_sel;
    logic [SLOTS-1:0] reclaim;
    logic [CW-1:0]    dec_a;
    logic [CW-1:0]    dec_b;
    logic             elig_a;
    logic             elig_b;
    logic             grant_a;
    logic             grant_b;
    logic             grant;

    // Scanning from the top down leaves the lowest free index as the final pick.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        free_sel = SLOTS'(1) << free_idx;
    end

    always_comb begin
        reclaim = bus.slot_done & busy_q;
        dec_a   = '0;
        dec_b   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (reclaim[i]) begin
                if (owner_q[i]) dec_b = dec_b + CW'(1);
                else            dec_a = dec_a + CW'(1);
            end
        end
    end

    // Round-robin only matters when both players are eligible in the same cycle.
    always_comb begin
        elig_a  = bus.fire_a && (cd_a_q == 8'd0) && (cnt_a_q < CW'(MAX_PER)) && free_any;
        elig_b  = bus.fire_b && (cd_b_q == 8'd0) && (cnt_b_q < CW'(MAX_PER)) && free_any;
        grant_a = elig_a && (!elig_b || !rr_q);
        grant_b = elig_b && (!elig_a || rr_q);
        grant   = grant_a || grant_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            owner_q <= '0;
            trig_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            cd_a_q  <= '0;
            cd_b_q  <= '0;
            rr_q    <= 1'b0;
        end else begin
            trig_q  <= grant ? free_sel : '0;
            ack_a_q <= grant_a;
            ack_b_q <= grant_b;
            busy_q  <= (busy_q & ~reclaim) | (grant ? free_sel : '0);
            cnt_a_q <= cnt_a_q + CW'(grant_a) - dec_a;
            cnt_b_q <= cnt_b_q + CW'(grant_b) - dec_b;
            if (grant) begin
                owner_q[free_idx] <= grant_b;
                x_q <= grant_b ? bus.pos_b_x : bus.pos_a_x;
                y_q <= grant_b ? bus.pos_b_y : bus.pos_a_y;
                d_q <= grant_b ? bus.dir_b   : bus.dir_a;
            end
            if (elig_a && elig_b) rr_q <= ~rr_q;

            if (grant_a)                         cd_a_q <= 8'(COOLDOWN);
            else if (bus.timer && cd_a_q != 8'd0) cd_a_q <= cd_a_q - 8'd1;
            if (grant_b)                         cd_b_q <= 8'(COOLDOWN);
            else if (bus.timer && cd_b_q != 8'd0) cd_b_q <= cd_b_q - 8'd1;
        end
    end

    assign bus.slot_trig  = trig_q;
    assign bus.slot_x     = x_q;
    assign bus.slot_y     = y_q;
    assign bus.slot_d     = d_q;
    assign bus.slot_busy  = busy_q;
    assign bus.slot_owner = owner_q;
    assign bus.ack_a      = ack_a_q;
    assign bus.ack_b      = ack_b_q;
endmodule

// File: tb/tb_bullet_sched.sv
// Bench for bullet_sched: a fixed vector table, hand-written corner sequences,
// and randomized traffic checked against a slot-array model of the scheduling rules.
module tb_bullet_sched;
    localparam int SLOTS    = 4;
    localparam int MAX_PER  = 2;
    localparam int COOLDOWN = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [10:0] hold_x = '0;
    logic [10:0] hold_y = '0;
    logic        hold_d = 1'b0;

    bit  m_busy  [SLOTS];
    bit  m_owner [SLOTS];
    int  m_cd_a;
    int  m_cd_b;
    bit  m_rr;

    typedef struct {
        int       reps;
        logic     fa;
        logic     fb;
        logic     t;
        logic [3:0] done;
        logic [3:0] trig;
        logic     acka;
        logic     ackb;
        logic [3:0] busy;
        logic [3:0] owner;
    } vec_t;

    vec_t tbl[13];

    bullet_sched_if #(.SLOTS(SLOTS)) bus ();

    bullet_sched #(.SLOTS(SLOTS), .MAX_PER(MAX_PER), .COOLDOWN(COOLDOWN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0h expected %0h", tag, field, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic fa, input logic fb, input logic t, input logic [3:0] done);
        bus.fire_a    = fa;
        bus.fire_b    = fb;
        bus.timer     = t;
        bus.slot_done = done;
        @(posedge clk);
        #1;
    endtask

    // Expected payload follows whichever player the caller expects to be acked.
    task automatic checkOutput(input string tag, input logic [3:0] trig, input logic acka,
                               input logic ackb, input logic [3:0] busy, input logic [3:0] owner);
        if (acka) begin
            hold_x = bus.pos_a_x; hold_y = bus.pos_a_y; hold_d = bus.dir_a;
        end else if (ackb) begin
            hold_x = bus.pos_b_x; hold_y = bus.pos_b_y; hold_d = bus.dir_b;
        end
        chk(tag, "trig",  int'(bus.slot_trig), int'(trig));
        chk(tag, "ack_a", int'(bus.ack_a), int'(acka));
        chk(tag, "ack_b", int'(bus.ack_b), int'(ackb));
        chk(tag, "busy",  int'(bus.slot_busy), int'(busy));
        chk(tag, "owner", int'(bus.slot_owner & bus.slot_busy), int'(owner));
        chk(tag, "x",     int'(bus.slot_x), int'(hold_x));
        chk(tag, "y",     int'(bus.slot_y), int'(hold_y));
        chk(tag, "d",     int'(bus.slot_d), int'(hold_d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.fire_a = 1'b0; bus.fire_b = 1'b0; bus.timer = 1'b0; bus.slot_done = '0;
        hold_x = '0; hold_y = '0; hold_d = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_fixed_pos();
        bus.pos_a_x = 11'd100; bus.pos_a_y = 11'd200; bus.dir_a = 1'b1;
        bus.pos_b_x = 11'd300; bus.pos_b_y = 11'd400; bus.dir_b = 1'b0;
    endtask

    // Live counts are derived from the slot array, never stored separately.
    task automatic model_step(input logic fa, input logic fb, input logic t, input logic [3:0] done,
                              output logic [3:0] trig, output logic acka, output logic ackb,
                              output logic [3:0] busy, output logic [3:0] owner);
        int cnt_a = 0, cnt_b = 0, free = -1, win = 0;
        bit ea, eb;
        for (int i = 0; i < SLOTS; i++) begin
            if (m_busy[i]) begin
                if (m_owner[i]) cnt_b++; else cnt_a++;
            end else if (free < 0) free = i;
        end
        ea = fa && m_cd_a == 0 && cnt_a < MAX_PER && free >= 0;
        eb = fb && m_cd_b == 0 && cnt_b < MAX_PER && free >= 0;
        if (ea && eb) begin
            win  = m_rr ? 2 : 1;
            m_rr = (win == 1);
        end else if (ea) win = 1;
        else if (eb) win = 2;
        for (int i = 0; i < SLOTS; i++) if (done[i]) m_busy[i] = 0;
        trig = '0;
        if (win != 0) begin
            m_busy[free]  = 1;
            m_owner[free] = (win == 2);
            trig[free]    = 1'b1;
        end
        if (win == 1) m_cd_a = COOLDOWN; else if (t && m_cd_a > 0) m_cd_a--;
        if (win == 2) m_cd_b = COOLDOWN; else if (t && m_cd_b > 0) m_cd_b--;
        acka = (win == 1);
        ackb = (win == 2);
        for (int i = 0; i < SLOTS; i++) begin
            busy[i]  = m_busy[i];
            owner[i] = m_busy[i] && m_owner[i];
        end
    endtask

    initial begin
        logic [3:0] e_trig, e_busy, e_owner, done;
        logic       e_acka, e_ackb, fa, fb, t;

        bus.fire_a = 1'b0; bus.fire_b = 1'b0; bus.timer = 1'b0; bus.slot_done = '0;
        set_fixed_pos();

        tbl[0]  = '{1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000};
        tbl[1]  = '{1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000};
        tbl[2]  = '{1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, 4'b0011, 4'b0010};
        tbl[3]  = '{1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0010};
        tbl[4]  = '{8, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0010};
        tbl[5]  = '{1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 4'b0111, 4'b0010};
        tbl[6]  = '{1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'b1111, 4'b1010};
        tbl[7]  = '{8, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b1010};
        tbl[8]  = '{1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b1010};
        tbl[9]  = '{1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b1110, 4'b1010};
        tbl[10] = '{1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 4'b1111, 4'b1010};
        tbl[11] = '{1, 1'b0, 1'b1, 1'b0, 4'b1100, 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0010};
        tbl[12] = '{1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'b0111, 4'b0110};

        #2;
        checkOutput("reset", 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 13; v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                applyStimulus(tbl[v].fa, tbl[v].fb, tbl[v].t, tbl[v].done);
                checkOutput($sformatf("vec%0d_%0d", v, r), tbl[v].trig, tbl[v].acka,
                            tbl[v].ackb, tbl[v].busy, tbl[v].owner);
            end
        end

        // Three slots are live here; reset must clear everything before any edge.
        #2;
        rst = 1'b0;
        #1;
        hold_x = '0; hold_y = '0; hold_d = 1'b0;
        checkOutput("async_rst", 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000);
        bus.fire_a = 1'b0; bus.fire_b = 1'b0; bus.slot_done = '0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("post_rst_fire", 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000);

        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("sim_grant0", 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            checkOutput("sim_cool1", 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001);
        checkOutput("sim_grant_done", 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            checkOutput("sim_cool2", 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("sim_second", 4'b0001, 1'b1, 1'b0, 4'b0011, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
            checkOutput("sim_cool3", 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("sim_capped", 4'b0000, 1'b0, 1'b0, 4'b0011, 4'b0000);

        do_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_busy[i] = 0; m_owner[i] = 0;
        end
        m_cd_a = 0; m_cd_b = 0; m_rr = 0;
        for (int n = 0; n < 600; n++) begin
            fa = ($urandom_range(0, 9) < 7);
            fb = ($urandom_range(0, 9) < 7);
            t  = ($urandom_range(0, 3) != 0);
            done = '0;
            for (int i = 0; i < SLOTS; i++) begin
                if (m_busy[i] && $urandom_range(0, 5) == 0) done[i] = 1'b1;
                if (!m_busy[i] && $urandom_range(0, 9) == 0) done[i] = 1'b1;
            end
            bus.pos_a_x = 11'($urandom_range(0, 2047));
            bus.pos_a_y = 11'($urandom_range(0, 2047));
            bus.pos_b_x = 11'($urandom_range(0, 2047));
            bus.pos_b_y = 11'($urandom_range(0, 2047));
            bus.dir_a   = 1'($urandom_range(0, 1));
            bus.dir_b   = 1'($urandom_range(0, 1));
            model_step(fa, fb, t, done, e_trig, e_acka, e_ackb, e_busy, e_owner);
            applyStimulus(fa, fb, t, done);
            checkOutput($sformatf("rand%0d", n), e_trig, e_acka, e_ackb, e_busy, e_owner);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
